// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation encoding and default operand width.
package alu_pkg;

    // Default operand/result width in bits.
    localparam int unsigned ALU_WIDTH_DEFAULT = 1;

    // Operation select encoding.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_datapath.sv
// Combinational ALU datapath: bitwise AND/OR/XOR and wrapping ADD.
// Ports:
//   a_i    - first operand, unsigned
//   b_i    - second operand, unsigned
//   op_i   - operation select
//   res_c  - combinational result (carry-out of ADD is discarded)
module alu_datapath
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] res_c
);

    // Result select; ADD truncates to WIDTH so the carry wraps silently.
    always_comb begin
        res_c = '0;
        unique case (op_i)
            OP_AND:  res_c = a_i & b_i;
            OP_OR:   res_c = a_i | b_i;
            OP_XOR:  res_c = a_i ^ b_i;
            OP_ADD:  res_c = WIDTH'(a_i + b_i);
            default: res_c = '0;
        endcase
    end

endmodule : alu_datapath

// File: rtl/alu.sv
// ALU top: combinational datapath followed by a single output register.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset, clears ALU_out
//   A, B    - unsigned operands
//   ALU_Sel - operation select (00 AND, 01 OR, 10 XOR, 11 ADD)
//   ALU_out - registered result, one cycle after the inputs are sampled
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_out
);

    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a_i   (A),
        .b_i   (B),
        .op_i  (alu_op_e'(ALU_Sel)),
        .res_c (alu_out_d)
    );

    // Output register; reset overrides the computed result on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out_d;
        end
    end

    assign ALU_out = alu_out_q;

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic       a1, b1;
    logic [1:0] sel1;
    logic       out1;
    logic [7:0] a8, b8;
    logic [1:0] sel8;
    logic [7:0] out8;

    int errors = 0;
    int checks = 0;

    alu #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a1),
        .B       (b1),
        .ALU_Sel (sel1),
        .ALU_out (out1)
    );

    alu #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a8),
        .B       (b8),
        .ALU_Sel (sel8),
        .ALU_out (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t tt1 [16];
    vec_t tt8 [7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // WIDTH=1 truth table: {a, b, sel, expected}, hand computed.
        tt1[0]  = '{8'd0, 8'd0, 2'b00, 8'd0};
        tt1[1]  = '{8'd0, 8'd1, 2'b00, 8'd0};
        tt1[2]  = '{8'd1, 8'd0, 2'b00, 8'd0};
        tt1[3]  = '{8'd1, 8'd1, 2'b00, 8'd1};
        tt1[4]  = '{8'd0, 8'd0, 2'b01, 8'd0};
        tt1[5]  = '{8'd0, 8'd1, 2'b01, 8'd1};
        tt1[6]  = '{8'd1, 8'd0, 2'b01, 8'd1};
        tt1[7]  = '{8'd1, 8'd1, 2'b01, 8'd1};
        tt1[8]  = '{8'd0, 8'd0, 2'b10, 8'd0};
        tt1[9]  = '{8'd0, 8'd1, 2'b10, 8'd1};
        tt1[10] = '{8'd1, 8'd0, 2'b10, 8'd1};
        tt1[11] = '{8'd1, 8'd1, 2'b10, 8'd0};
        tt1[12] = '{8'd0, 8'd0, 2'b11, 8'd0};
        tt1[13] = '{8'd0, 8'd1, 2'b11, 8'd1};
        tt1[14] = '{8'd1, 8'd0, 2'b11, 8'd1};
        tt1[15] = '{8'd1, 8'd1, 2'b11, 8'd0};

        // WIDTH=8 vectors, including carry wrap.
        tt8[0] = '{8'hFF, 8'h01, 2'b11, 8'h00};
        tt8[1] = '{8'hA5, 8'h0F, 2'b10, 8'hAA};
        tt8[2] = '{8'hA5, 8'h0F, 2'b00, 8'h05};
        tt8[3] = '{8'hA5, 8'h0F, 2'b01, 8'hAF};
        tt8[4] = '{8'h80, 8'h80, 2'b11, 8'h00};
        tt8[5] = '{8'h12, 8'h34, 2'b11, 8'h46};
        tt8[6] = '{8'h3C, 8'hFF, 2'b10, 8'hC3};

        // Reset held for two edges with non-zero inputs.
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; sel1 = 2'b00;
        a8 = 8'hFF; b8 = 8'hFF; sel8 = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset1_edge%0d", i), 8'(out1), 8'h00);
            check($sformatf("reset8_edge%0d", i), out8, 8'h00);
        end

        // Select sweep with A=B=1, back-to-back; first edge after release registers normally.
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        begin
            logic [7:0] sweep_exp [4];
            sweep_exp[0] = 8'd1; sweep_exp[1] = 8'd1; sweep_exp[2] = 8'd0; sweep_exp[3] = 8'd0;
            for (int s = 0; s < 4; s++) begin
                sel1 = 2'(s);
                tick();
                check($sformatf("sweep_sel%0d", s), 8'(out1), sweep_exp[s]);
            end
        end

        // Full WIDTH=1 truth table.
        foreach (tt1[i]) begin
            a1 = tt1[i].a[0];
            b1 = tt1[i].b[0];
            sel1 = tt1[i].sel;
            tick();
            check($sformatf("tt1_%0d", i), 8'(out1), tt1[i].exp);
        end

        // WIDTH=8 vectors.
        foreach (tt8[i]) begin
            a8 = tt8[i].a;
            b8 = tt8[i].b;
            sel8 = tt8[i].sel;
            tick();
            check($sformatf("tt8_%0d", i), out8, tt8[i].exp);
        end

        // Hold: toggle inputs between edges; outputs stay at last registered values (8'hC3, 1'b0).
        a8 = 8'h00; b8 = 8'h11; sel8 = 2'b01;
        a1 = ~a1; sel1 = 2'b01;
        #3;
        check("hold8_a", out8, 8'hC3);
        check("hold1_a", 8'(out1), 8'h00);
        a8 = 8'h77; b8 = 8'h88; sel8 = 2'b11;
        b1 = 1'b1; a1 = 1'b1; sel1 = 2'b00;
        #3;
        check("hold8_b", out8, 8'hC3);
        check("hold1_b", 8'(out1), 8'h00);
        // The next edge picks up the latest inputs: 77+88 = FF, 1&1 = 1.
        tick();
        check("hold8_edge", out8, 8'hFF);
        check("hold1_edge", 8'(out1), 8'h01);

        // Mid-stream reset during an ADD sequence.
        a8 = 8'h10; b8 = 8'h20; sel8 = 2'b11;
        tick();
        check("midrst_pre", out8, 8'h30);
        a8 = 8'h01; b8 = 8'h02;
        rst_n = 1'b0;
        tick();
        check("midrst_edge8", out8, 8'h00);
        check("midrst_edge1", 8'(out1), 8'h00);
        rst_n = 1'b1;
        tick();
        check("midrst_post8", out8, 8'h03);
        check("midrst_post1", 8'(out1), 8'h01);
        a8 = 8'hF0; b8 = 8'h20;
        tick();
        check("midrst_next8", out8, 8'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu
